// File: rtl/msi_irq_arbiter.sv
// Round-robin arbiter that funnels N_SRC edge-triggered interrupt sources onto one MSI request port.
// Events are latched per source and retried after a timeout or when MSI is disabled.
module msi_irq_arbiter #(
  parameter int N_SRC    = 4,
  parameter int VEC_BASE = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic             axi_clk_pcie,
  input  logic             sys_reset,
  input  logic [N_SRC-1:0] irq_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             msi_enabled,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [4:0]       msi_vector_num,
  output logic [N_SRC-1:0] irq_ack_o,
  output logic [N_SRC-1:0] pending_o
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q;
  logic [N_SRC-1:0]   irq_prev_q;
  logic [N_SRC-1:0]   pending_q;
  logic [N_SRC-1:0]   pending_d;
  logic [N_SRC-1:0]   ack_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   cur_idx_q;
  logic [15:0]        to_cnt_q;
  logic               req_q;
  logic [4:0]         vec_q;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   grant_clr;
  logic               grant_hit;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   next_ptr;
  logic [4:0]         sel_vec;

  assign rise      = irq_i & ~irq_prev_q;
  assign eligible  = pending_q & ~irq_mask_i;
  assign grant_hit = (state_q == S_REQ) && msi_grant;
  assign grant_clr = grant_hit ? ({{(N_SRC-1){1'b0}}, 1'b1} << cur_idx_q) : '0;
  // A rise coinciding with the grant re-arms the same source.
  assign pending_d = (pending_q & ~grant_clr) | rise;
  assign next_ptr  = (cur_idx_q == IDX_LAST) ? '0 : cur_idx_q + 1'b1;
  assign sel_vec   = 5'(VEC_BASE) + {{(5-IDX_W){1'b0}}, sel_idx};

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_SRC)) begin
        cand = cand - (IDX_W+1)'(N_SRC);
      end
      if (!sel_found && eligible[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge axi_clk_pcie) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      ack_q      <= '0;
      rr_ptr_q   <= '0;
      cur_idx_q  <= '0;
      to_cnt_q   <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
    end else begin
      irq_prev_q <= irq_i;
      pending_q  <= pending_d;
      ack_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (msi_enabled && sel_found) begin
            cur_idx_q <= sel_idx;
            req_q     <= 1'b1;
            vec_q     <= sel_vec;
            to_cnt_q  <= '0;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          // Grant wins over both disable and timeout in the same cycle.
          if (msi_grant) begin
            ack_q    <= grant_clr;
            rr_ptr_q <= next_ptr;
            req_q    <= 1'b0;
            vec_q    <= '0;
            to_cnt_q <= '0;
            state_q  <= S_GAP;
          end else if (!msi_enabled) begin
            req_q    <= 1'b0;
            vec_q    <= '0;
            to_cnt_q <= '0;
            state_q  <= S_GAP;
          end else if (to_cnt_q == TO_LAST) begin
            rr_ptr_q <= next_ptr;
            req_q    <= 1'b0;
            vec_q    <= '0;
            to_cnt_q <= '0;
            state_q  <= S_GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          vec_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign msi_request    = req_q;
  assign msi_vector_num = vec_q;
  assign irq_ack_o      = ack_q;
  assign pending_o      = pending_q;

endmodule

// File: tb/tb_msi_irq_arbiter.sv
// Directed bench for msi_irq_arbiter: single event, round-robin, timeout, mask/enable, collision, reset.
module tb_msi_irq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq;
  logic [3:0] mask;
  logic       en;
  logic       grant;
  logic       req;
  logic [4:0] vec;
  logic [3:0] ack;
  logic [3:0] pend;

  int n_tests = 0;
  int n_fail  = 0;
  int hi;

  always #5 clk = ~clk;

  msi_irq_arbiter #(.N_SRC(4), .VEC_BASE(0), .TIMEOUT(8)) dut (
    .axi_clk_pcie  (clk),
    .sys_reset     (rst),
    .irq_i         (irq),
    .irq_mask_i    (mask),
    .msi_enabled   (en),
    .msi_grant     (grant),
    .msi_request   (req),
    .msi_vector_num(vec),
    .irq_ack_o     (ack),
    .pending_o     (pend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int k = 0;
    while (!req && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_wait"}, 32'(req), 32'h1);
  endtask

  task automatic do_reset();
    irq = 4'b0; mask = 4'b0; en = 1'b1; grant = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = 4'b0; mask = 4'b0; en = 1'b1; grant = 1'b0;
    tick(); tick(); tick();
    chk("rst_req",  32'(req),  32'h0);
    chk("rst_vec",  32'(vec),  32'h0);
    chk("rst_ack",  32'(ack),  32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    tick();

    // single event on source 2
    irq = 4'b0100;
    tick();
    chk("s1_pend", 32'(pend), 32'h4);
    chk("s1_noreq", 32'(req), 32'h0);
    tick();
    chk("s1_req", 32'(req), 32'h1);
    chk("s1_vec", 32'(vec), 32'h2);
    tick();
    chk("s1_hold", 32'(req), 32'h1);
    tick();
    chk("s1_hold_vec", 32'(vec), 32'h2);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("s1_ack", 32'(ack), 32'h4);
    chk("s1_pend_clr", 32'(pend), 32'h0);
    chk("s1_req_low", 32'(req), 32'h0);
    chk("s1_vec_zero", 32'(vec), 32'h0);
    tick();
    chk("s1_ack_pulse", 32'(ack), 32'h0);

    // round robin 0, 3, 0
    do_reset();
    irq = 4'b1001;
    tick();
    chk("rr_pend", 32'(pend), 32'h9);
    tick();
    chk("rr_req0", 32'(req), 32'h1);
    chk("rr_vec0", 32'(vec), 32'h0);
    grant = 1'b1;
    tick();
    chk("rr_ack0", 32'(ack), 32'h1);
    chk("rr_pend_a", 32'(pend), 32'h8);
    grant = 1'b0; irq = 4'b1000;
    tick();
    chk("rr_gap0", 32'(req), 32'h0);
    irq = 4'b1001;
    tick();
    chk("rr_req3", 32'(req), 32'h1);
    chk("rr_vec3", 32'(vec), 32'h3);
    chk("rr_pend_b", 32'(pend), 32'h9);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("rr_ack3", 32'(ack), 32'h8);
    chk("rr_gap3", 32'(req), 32'h0);
    wait_req("rr_req0b", 4);
    chk("rr_vec0b", 32'(vec), 32'h0);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("rr_ack0b", 32'(ack), 32'h1);
    chk("rr_pend_end", 32'(pend), 32'h0);

    // timeout with source 1, source 2 arrives meanwhile
    do_reset();
    irq = 4'b0010;
    tick(); tick();
    chk("to_req", 32'(req), 32'h1);
    chk("to_vec", 32'(vec), 32'h1);
    hi = 0;
    for (int k = 0; k < 20 && req; k++) begin
      hi++;
      if (k == 2) irq = 4'b0110;
      tick();
    end
    chk("to_high_cycles", 32'(hi), 32'd8);
    chk("to_no_ack", 32'(ack), 32'h0);
    chk("to_pend_kept", 32'(pend), 32'h6);
    wait_req("to_next", 4);
    chk("to_next_vec", 32'(vec), 32'h2);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("to_next_ack", 32'(ack), 32'h4);

    // mask, stray grant, unmask, disable in REQ
    do_reset();
    mask = 4'b0010; irq = 4'b0010;
    tick(); tick();
    chk("mk_pend", 32'(pend), 32'h2);
    chk("mk_noreq", 32'(req), 32'h0);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("mk_stray_ack", 32'(ack), 32'h0);
    chk("mk_stray_pend", 32'(pend), 32'h2);
    mask = 4'b0000;
    tick();
    chk("mk_unmask_req", 32'(req), 32'h1);
    chk("mk_unmask_vec", 32'(vec), 32'h1);
    en = 1'b0;
    tick();
    chk("en_drop_req", 32'(req), 32'h0);
    chk("en_drop_vec", 32'(vec), 32'h0);
    chk("en_drop_pend", 32'(pend), 32'h2);
    en = 1'b1;
    wait_req("en_rereq", 4);
    chk("en_rereq_vec", 32'(vec), 32'h1);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("en_ack", 32'(ack), 32'h2);

    // rise coincident with grant on source 1
    do_reset();
    irq = 4'b0010;
    tick(); tick();
    chk("co_req", 32'(req), 32'h1);
    irq = 4'b0000;
    tick();
    irq = 4'b0010; grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("co_ack", 32'(ack), 32'h2);
    chk("co_pend_kept", 32'(pend), 32'h2);
    wait_req("co_second", 4);
    chk("co_second_vec", 32'(vec), 32'h1);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("co_second_ack", 32'(ack), 32'h2);
    chk("co_pend_clr", 32'(pend), 32'h0);

    // reset while requesting, sources held high across release
    do_reset();
    irq = 4'b0111;
    tick(); tick();
    chk("rq_req", 32'(req), 32'h1);
    rst = 1'b1;
    tick();
    chk("rq_req_drop", 32'(req), 32'h0);
    chk("rq_pend_clr", 32'(pend), 32'h0);
    chk("rq_vec_zero", 32'(vec), 32'h0);
    tick();
    chk("rq_req_in_rst", 32'(req), 32'h0);
    rst = 1'b0;
    tick();
    chk("rq_relatch", 32'(pend), 32'h7);
    tick();
    chk("rq_after_req", 32'(req), 32'h1);
    chk("rq_after_vec", 32'(vec), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
